// File: rtl/taillight_scheduler.sv
// rtl/taillight_scheduler.sv - rear lamp sequencer: step prescaler, request arbitration, registered lamp patterns.
// Optional TAIL_SEQ_EXT_STEP_EN replaces the prescaler with an external step_en_i strobe.
module taillight_scheduler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic left_i,
    input  logic right_i,
    input  logic brake_i,
    input  logic hazard_i,
`ifdef TAIL_SEQ_EXT_STEP_EN
    input  logic step_en_i,
`endif
    output logic tick_o,
    output logic busy_o,
    output logic la_o,
    output logic lb_o,
    output logic lc_o,
    output logic ra_o,
    output logic rb_o,
    output logic rc_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TURN_L = 3'd1,
        TURN_R = 3'd2,
        HAZ    = 3'd3,
        BRK    = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [5:0]  lamps_q, lamps_d;   // {la,lb,lc,ra,rb,rc}
    logic        tick;

`ifdef TAIL_SEQ_EXT_STEP_EN
    assign tick = step_en_i;
`else
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    function automatic logic [2:0] turn_pat(input logic [1:0] s);
        case (s)
            2'd1:    turn_pat = 3'b100;
            2'd2:    turn_pat = 3'b110;
            2'd3:    turn_pat = 3'b111;
            default: turn_pat = 3'b000;
        endcase
    endfunction

    logic       haz_req;
    logic       own_req;
    logic [1:0] step_nx;
    state_e     arb;
    logic [1:0] ent_step;
    logic [5:0] ent_lamps;
    logic [5:0] turn_lamps;

    assign haz_req = hazard_i | (left_i & right_i);
    assign own_req = (state_q == TURN_L) ? left_i : right_i;
    assign step_nx = step_q + 2'd1;

    always_comb begin
        arb = IDLE;
        if (haz_req) begin
            arb = HAZ;
        end else if (left_i) begin
            arb = TURN_L;
        end else if (right_i) begin
            arb = TURN_R;
        end else if (brake_i) begin
            arb = BRK;
        end
    end

    // Lamps and step for the first tick spent in the arbitrated state.
    always_comb begin
        ent_step  = 2'd1;
        ent_lamps = 6'b000000;
        case (arb)
            TURN_L:   ent_lamps = {3'b100, {3{brake_i}}};
            TURN_R:   ent_lamps = {{3{brake_i}}, 3'b100};
            HAZ, BRK: ent_lamps = 6'b111111;
            default:  ent_step  = 2'd0;
        endcase
    end

    // The side opposite the turn follows brake every tick, independent of step.
    assign turn_lamps = (state_q == TURN_L) ? {turn_pat(step_nx), {3{brake_i}}}
                                            : {{3{brake_i}}, turn_pat(step_nx)};

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        lamps_d = lamps_q;
        if (tick) begin
            case (state_q)
                IDLE, BRK: begin
                    state_d = arb;
                    step_d  = ent_step;
                    lamps_d = ent_lamps;
                end
                TURN_L, TURN_R: begin
                    if (haz_req || (step_q == 2'd0 && !own_req)) begin
                        state_d = arb;
                        step_d  = ent_step;
                        lamps_d = ent_lamps;
                    end else begin
                        step_d  = step_nx;
                        lamps_d = turn_lamps;
                    end
                end
                HAZ: begin
                    // step 1 = on phase, step 0 = off phase; leave only from off.
                    if (step_q != 2'd0) begin
                        step_d  = 2'd0;
                        lamps_d = 6'b000000;
                    end else begin
                        state_d = arb;
                        step_d  = ent_step;
                        lamps_d = ent_lamps;
                    end
                end
                default: begin
                    state_d = IDLE;
                    step_d  = 2'd0;
                    lamps_d = 6'b000000;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            lamps_q <= 6'b000000;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            lamps_q <= lamps_d;
        end
    end

    assign tick_o = tick;
    assign busy_o = (state_q != IDLE);
    assign {la_o, lb_o, lc_o, ra_o, rb_o, rc_o} = lamps_q;

endmodule
